// File: rtl/pp_accumulator_if.sv
// Beat and result bundle for the partial-product accumulator.
// The producer and drain side use master; the accumulator uses slave.
interface pp_accumulator_if #(
    parameter int COEFF_W = 18,
    parameter int IDX_W   = 11
);
    logic                 B_valid;
    logic                 B_ready;
    logic [IDX_W-1:0]     idx_B;
    logic [3*COEFF_W-1:0] B_in;
    logic [9:0]           h_in;
    logic                 res_valid;
    logic                 res_ready;
    logic [9:0]           res_idx;
    logic [COEFF_W-1:0]   res_data;
    logic [9:0]           res_h;
    logic                 err_idx;
    logic                 err_h;

    modport master (
        output B_valid, idx_B, B_in, h_in, res_ready,
        input  B_ready, res_valid, res_idx, res_data, res_h,
        input  err_idx, err_h
    );

    modport slave (
        input  B_valid, idx_B, B_in, h_in, res_ready,
        output B_ready, res_valid, res_idx, res_data, res_h,
        output err_idx, err_h
    );
endinterface

// File: rtl/pp_accumulator.sv
// Folds 3-lane partial products into a DEPTH-term polynomial, then drains it.
// Build option PP_ACC_CYCLIC_EN: wrapped lanes add (x^DEPTH = 1) instead of subtract.
module pp_accumulator #(
    parameter int DEPTH     = 784,
    parameter int COEFF_W   = 18,
    parameter int IDX_W     = 11,
    parameter int NUM_BEATS = 153664
) (
    input logic             clk_in,
    input logic             rst_in,
    pp_accumulator_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(NUM_BEATS + 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [CW-1:0]    LAST_BEAT = CW'(NUM_BEATS - 1);
    localparam logic [9:0]       LAST_IDX  = 10'(DEPTH - 1);
    localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(2 * DEPTH - 3);
    localparam logic [IDX_W:0]   DEPTH_P   = (IDX_W + 1)'(DEPTH);

    logic [0:0]         state;
    logic [CW-1:0]      beat_cnt;
    logic [COEFF_W-1:0] acc [DEPTH];
    logic [9:0]         rd_idx;
    logic [9:0]         tag;
    logic               err_idx_q;
    logic               err_h_q;

    logic               beat_fire;
    logic               beat_ok;
    logic               res_fire;
    logic [IDX_W:0]     pos  [3];
    logic               wrap [3];
    logic [AW-1:0]      tgt  [3];
    logic [COEFF_W-1:0] lane [3];
    logic [COEFF_W-1:0] nxt  [3];

    assign beat_fire = (state == ACCUM) && bus.B_valid;
    assign beat_ok   = beat_fire && (bus.idx_B <= MAX_IDX);
    assign res_fire  = (state == DRAIN) && bus.res_ready;

    // Fold each lane's position into range and form its updated coefficient.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            pos[k]  = {1'b0, bus.idx_B} + (IDX_W + 1)'(k);
            wrap[k] = pos[k] >= DEPTH_P;
            tgt[k]  = wrap[k] ? AW'(pos[k] - DEPTH_P) : AW'(pos[k]);
            lane[k] = bus.B_in[k*COEFF_W +: COEFF_W];
`ifdef PP_ACC_CYCLIC_EN
            nxt[k]  = acc[tgt[k]] + lane[k];
`else
            nxt[k]  = wrap[k] ? acc[tgt[k]] - lane[k]
                              : acc[tgt[k]] + lane[k];
`endif
        end
    end

    // Coefficient store: three distinct lane writes per beat, clear on drain.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                acc[i] <= '0;
            end
        end else if (beat_ok) begin
            for (int k = 0; k < 3; k++) begin
                acc[tgt[k]] <= nxt[k];
            end
        end else if (res_fire) begin
            acc[rd_idx[AW-1:0]] <= '0;
        end
    end

    // Frame sequencing: beat counting, tag capture, drain pointer, sticky errors.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ACCUM;
            beat_cnt  <= '0;
            rd_idx    <= '0;
            tag       <= '0;
            err_idx_q <= 1'b0;
            err_h_q   <= 1'b0;
        end else begin
            if (beat_fire) begin
                if (beat_cnt == '0) begin
                    tag <= bus.h_in;
                end else if (bus.h_in != tag) begin
                    err_h_q <= 1'b1;
                end
                if (!beat_ok) begin
                    err_idx_q <= 1'b1;
                end
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                    state    <= DRAIN;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
            if (res_fire) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx <= '0;
                    state  <= ACCUM;
                end else begin
                    rd_idx <= rd_idx + 10'd1;
                end
            end
        end
    end

    assign bus.B_ready   = (state == ACCUM);
    assign bus.res_valid = (state == DRAIN);
    assign bus.res_idx   = rd_idx;
    assign bus.res_data  = acc[rd_idx[AW-1:0]];
    assign bus.res_h     = tag;
    assign bus.err_idx   = err_idx_q;
    assign bus.err_h     = err_h_q;
endmodule

// File: tb/tb_pp_accumulator.sv
// Scoreboard bench for pp_accumulator at DEPTH=8, NUM_BEATS=2.
// Expected coefficients come from a signed polynomial model folded at frame end.
module tb_pp_accumulator;
    localparam int D    = 8;
    localparam int NB   = 2;
    localparam int CWID = 18;
    localparam int MASK = 32'h3FFFF;
`ifdef PP_ACC_CYCLIC_EN
    localparam int WSIGN = 1;
`else
    localparam int WSIGN = -1;
`endif

    typedef struct {
        int idx;
        int data;
        int h;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    pp_accumulator_if #(.COEFF_W(CWID), .IDX_W(11)) bus ();

    pp_accumulator #(
        .DEPTH(D), .COEFF_W(CWID), .IDX_W(11), .NUM_BEATS(NB)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   coef[D];
    int   beat_n = 0;
    int   tag_exp = 0;
    bit   err_idx_exp = 0;
    bit   err_h_exp = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) coef[i] = 0;
        beat_n      = 0;
        tag_exp     = 0;
        err_idx_exp = 0;
        err_h_exp   = 0;
    endtask

    // Polynomial model: lane k lands on x^(idx+k); x^D folds back with WSIGN.
    task automatic model_beat(int idx, int l0, int l1, int l2, int h);
        int l[3];
        int p;
        l = '{l0, l1, l2};
        if (idx > 2 * D - 3) begin
            err_idx_exp = 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                p = idx + k;
                if (p < D) coef[p] += l[k];
                else coef[p - D] += WSIGN * l[k];
            end
        end
        if (beat_n == 0) tag_exp = h;
        else if (h != tag_exp) err_h_exp = 1;
        beat_n++;
        if (beat_n == NB) begin
            for (int i = 0; i < D; i++) begin
                exp_q.push_back('{i, coef[i] & MASK, tag_exp});
                coef[i] = 0;
            end
            beat_n = 0;
        end
    endtask

    // Caller is at posedge+1; beat is taken on the next posedge.
    task automatic do_beat(int idx, int l0, int l1, int l2, int h);
        chk("b_ready_accum", {31'd0, bus.B_ready}, 1);
        bus.B_valid = 1'b1;
        bus.idx_B   = 11'(idx);
        bus.B_in    = {18'(l2), 18'(l1), 18'(l0)};
        bus.h_in    = 10'(h);
        model_beat(idx, l0 & MASK, l1 & MASK, l2 & MASK, h);
        @(posedge clk_in);
        #1;
        bus.B_valid = 1'b0;
    endtask

    task automatic rand_beat(int h);
        do_beat($urandom_range(2 * D - 3), $urandom & MASK,
                $urandom & MASK, $urandom & MASK, h);
    endtask

    task automatic do_drain(int stall_at, bit rnd_ready, bit junk_b);
        int  stalls = 0;
        bit  done   = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (!bus.res_valid && exp_q.size() == 0) begin
                done = 1;
            end else begin
                if (stall_at >= 0 && bus.res_idx == 10'(stall_at)
                    && stalls < 3) begin
                    bus.res_ready = 1'b0;
                    stalls++;
                end else begin
                    bus.res_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
                end
                if (junk_b) begin
                    bus.B_valid = 1'($urandom_range(1));
                    bus.idx_B   = 11'($urandom_range(2 * D - 3));
                    bus.B_in    = {$urandom, $urandom};
                    bus.h_in    = 10'($urandom);
                end
                @(posedge clk_in);
                #1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: queue %0d left, res_valid %0b",
                     exp_q.size(), bus.res_valid);
            exp_q.delete();
        end
        bus.res_ready = 1'b0;
        bus.B_valid   = 1'b0;
    endtask

    // Monitor: whenever a coefficient is presented, it must match the queue head.
    always @(negedge clk_in) begin
        if (rst_in && bus.res_valid) begin
            chk("b_ready_drain", {31'd0, bus.B_ready}, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_res: got idx %0d data 0x%0h, expected none",
                         bus.res_idx, bus.res_data);
            end else begin
                chk("res_idx", 32'(bus.res_idx), exp_q[0].idx);
                chk("res_data", 32'(bus.res_data), exp_q[0].data);
                chk("res_h", 32'(bus.res_h), exp_q[0].h);
                if (bus.res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int h;
        bit hit;
        bus.B_valid   = 1'b0;
        bus.idx_B     = '0;
        bus.B_in      = '0;
        bus.h_in      = '0;
        bus.res_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_b_ready", {31'd0, bus.B_ready}, 1);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 0);
        chk("rst_res_idx", 32'(bus.res_idx), 0);
        chk("rst_res_data", 32'(bus.res_data), 0);
        chk("rst_res_h", 32'(bus.res_h), 0);
        chk("rst_err_idx", {31'd0, bus.err_idx}, 0);
        chk("rst_err_h", {31'd0, bus.err_h}, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        do_beat(0, 1, 2, 3, 5);
        do_beat(1, 10, 20, 30, 5);
        do_drain(-1, 0, 0);

        do_beat(6, 4, 5, 6, 7);
        do_beat(0, 0, 0, 0, 7);
        do_drain(-1, 0, 0);

        do_beat(0, 'h3FFFF, 0, 0, 1);
        do_beat(0, 2, 0, 0, 1);
        do_drain(-1, 0, 0);

        rand_beat(9);
        rand_beat(9);
        do_drain(2, 0, 1);
        rand_beat(11);
        rand_beat(11);
        do_drain(-1, 1, 0);
        chk("err_idx_clean", {31'd0, bus.err_idx}, 32'(err_idx_exp));
        chk("err_h_clean", {31'd0, bus.err_h}, 32'(err_h_exp));

        do_beat(15, 9, 9, 9, 3);
        do_beat(2, 1, 1, 1, 3);
        do_drain(-1, 0, 0);
        chk("err_idx_set", {31'd0, bus.err_idx}, 32'(err_idx_exp));
        chk("err_h_after_idx", {31'd0, bus.err_h}, 32'(err_h_exp));

        do_beat(0, 1, 1, 1, 5);
        do_beat(0, 2, 2, 2, 6);
        do_drain(-1, 0, 0);
        chk("err_h_set", {31'd0, bus.err_h}, 32'(err_h_exp));

        for (int f = 0; f < 20; f++) begin
            h = $urandom_range(1023);
            rand_beat(h);
            rand_beat(h);
            do_drain(-1, f[0], f[1]);
        end

        rand_beat(44);
        rand_beat(44);
        hit = 0;
        for (int n = 0; n < 50 && !hit; n++) begin
            bus.res_ready = 1'b1;
            if (bus.res_valid && bus.res_idx == 10'd3) hit = 1;
            else begin
                @(posedge clk_in);
                #1;
            end
        end
        chk("reach_idx3", {31'd0, hit}, 1);
        rst_in = 1'b0;
        bus.res_ready = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 0);
        chk("mid_rst_b_ready", {31'd0, bus.B_ready}, 1);
        chk("mid_rst_err_idx", {31'd0, bus.err_idx}, 0);
        chk("mid_rst_err_h", {31'd0, bus.err_h}, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        do_beat(3, 7, 8, 9, 2);
        do_beat(12, 100, 200, 300, 2);
        do_drain(-1, 1, 0);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
